writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 2, entries per source FIFO (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rstn  input  1  synchronous active-high reset (1 = reset asserted), sampled on clk.
REQ-004 SHALL have ports, for each source x in {alu, fpu, mem}: x_valid  input  1  write request present.
REQ-005 SHALL have ports: x_ready  output  1  source FIFO can accept this cycle.
REQ-006 SHALL have ports: x_fmode  input  1  target file (0 integer, 1 float).
REQ-007 SHALL have ports: x_reg  input  5  destination register index.
REQ-008 SHALL have ports: x_data  input  32  write data.
REQ-009 SHALL have port: wenable  output  1  register-file write strobe.
REQ-010 SHALL have port: wfmode  output  1  register-file select for the write.
REQ-011 SHALL have port: wreg  output  5  register-file write index.
REQ-012 SHALL have port: wdata  output  32  register-file write data.
REQ-013 SHALL have port: busy  output  1  any FIFO non-empty or output write pending.

Function
REQ-014 SHALL accept a request from source x on a rising edge where x_valid=1 and x_ready=1, pushing {fmode, reg, data} into that source's FIFO.
REQ-015 SHALL drive x_ready = (FIFO count < DEPTH) from registered count only; a pop in the same cycle does not raise ready on a full FIFO.
REQ-016 SHALL preserve per-source order; no reordering within a source.
REQ-017 SHALL grant at most one non-empty FIFO head per cycle using round-robin order alu->fpu->mem->alu, starting from the source after the last winner.
REQ-018 SHALL pop the granted head in the grant cycle and register it onto wenable/wfmode/wreg/wdata at the next rising edge.
REQ-019 SHALL give a minimum latency of one cycle: request accepted at edge E0 appears on the write port in the cycle after edge E1.
REQ-020 SHALL hold wenable=1 for exactly one cycle per granted entry; wenable=0 in cycles with no grant, wfmode/wreg/wdata then holding their last values.
REQ-021 SHALL consume but suppress writes with fmode=0 and reg=0 (wenable stays 0 for that slot).
REQ-022 SHALL sustain one write per cycle when any FIFO is non-empty; three-source full load gives each source one write every three cycles.
REQ-023 SHALL allow push and pop on the same FIFO in the same cycle with count unchanged.
REQ-024 SHALL perform no hazard checking between sources writing the same register; final value follows grant order.
REQ-025 SHALL wrap FIFO read/write pointers modulo DEPTH without loss.

Reset
REQ-026 SHALL, while rstn=1 at an edge, empty all FIFOs, set wenable=0, wfmode=0, wreg=0, wdata=0, busy=0, round-robin pointer to alu.
REQ-027 SHALL discard all buffered and pending writes on reset mid-operation; x_ready=1 in the cycle after reset deasserts.

Structure
REQ-028 SHALL take REG_W=5, DATA_W=32 and the source-index enumeration (ALU, FPU, MEM) from shared package core_pkg.
REQ-029 SHALL instantiate one sub-module wb_fifo (parameter DEPTH, count-based full/empty) per source.

Verification
REQ-030 SHALL check: single alu request fmode=0 reg=3 data=0x12345678 -> wenable=1 one cycle after acceptance with wreg=3, wdata=0x12345678, wfmode=0.
REQ-031 SHALL check: all three sources valid every cycle -> grants alu,fpu,mem,alu,... with one wenable per cycle, no source starved.
REQ-032 SHALL check: mem pushes 3 entries with no grants possible -> mem_ready=0 after 2 pushes (DEPTH=2); entries emerge in push order.
REQ-033 SHALL check: alu request fmode=0 reg=0 -> consumed, wenable stays 0; fpu request fmode=1 reg=0 -> wenable=1, wreg=0.
REQ-034 SHALL check: rstn=1 with all FIFOs full -> next cycle busy=0, wenable=0, all x_ready=1, no stale writes later.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: register/data widths, write-back source indices and the
// buffered write-back entry format.
package core_pkg;

  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 3;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_FPU = 2'd1,
    SRC_MEM = 2'd2
  } src_e;

  typedef struct packed {
    logic              fmode;
    logic [REG_W-1:0]  ridx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Round-robin successor: alu -> fpu -> mem -> alu.
  function automatic src_e src_next(input src_e s);
    case (s)
      SRC_ALU: return SRC_FPU;
      SRC_FPU: return SRC_MEM;
      default: return SRC_ALU;
    endcase
  endfunction

  // Integer x0 is hardwired; such writes are consumed but never strobed.
  function automatic logic is_null_write(input wb_entry_t e);
    return (!e.fmode) && (e.ridx == '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source write-back FIFO. Count-based full/empty; ready is derived from the
// registered count only, so a same-cycle pop never re-opens a full FIFO.
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_i,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  output logic      ready_o,
  input  logic      pop_i,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_push;
  logic          do_pop;

  assign ready_o = (count_q < CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && ready_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges alu/fpu/mem write-back streams onto one register-file write port.
// Handshake: a source transfer happens on a rising edge where x_valid && x_ready.
module writeback_arbiter
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic              alu_fmode,
  input  logic [REG_W-1:0]  alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              fpu_valid,
  output logic              fpu_ready,
  input  logic              fpu_fmode,
  input  logic [REG_W-1:0]  fpu_reg,
  input  logic [DATA_W-1:0] fpu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_fmode,
  input  logic [REG_W-1:0]  mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wenable,
  output logic              wfmode,
  output logic [REG_W-1:0]  wreg,
  output logic [DATA_W-1:0] wdata,
  output logic              busy
);

  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC-1:0] src_ready;
  logic [NUM_SRC-1:0] src_empty;
  logic [NUM_SRC-1:0] src_pop;
  wb_entry_t          src_in   [NUM_SRC];
  wb_entry_t          src_head [NUM_SRC];

  src_e               rr_q;
  src_e               rr_d;
  src_e               cand1;
  src_e               cand2;
  src_e               grant_idx;
  logic               grant_vld;
  wb_entry_t          gnt_entry;

  logic               wen_q;
  logic               wen_d;
  logic               wfmode_q;
  logic [REG_W-1:0]   wreg_q;
  logic [DATA_W-1:0]  wdata_q;

  assign src_valid = {mem_valid, fpu_valid, alu_valid};
  assign src_in[0] = {alu_fmode, alu_reg, alu_data};
  assign src_in[1] = {fpu_fmode, fpu_reg, fpu_data};
  assign src_in[2] = {mem_fmode, mem_reg, mem_data};

  assign alu_ready = src_ready[0];
  assign fpu_ready = src_ready[1];
  assign mem_ready = src_ready[2];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    wb_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst_i      (rstn),
      .push_i     (src_valid[g]),
      .push_data_i(src_in[g]),
      .ready_o    (src_ready[g]),
      .pop_i      (src_pop[g]),
      .empty_o    (src_empty[g]),
      .head_o     (src_head[g])
    );
  end

  // rr_q names the source with highest priority this cycle.
  always_comb begin
    cand1     = src_next(rr_q);
    cand2     = src_next(cand1);
    grant_vld = 1'b1;
    grant_idx = rr_q;
    if (!src_empty[rr_q]) begin
      grant_idx = rr_q;
    end else if (!src_empty[cand1]) begin
      grant_idx = cand1;
    end else if (!src_empty[cand2]) begin
      grant_idx = cand2;
    end else begin
      grant_vld = 1'b0;
    end
    gnt_entry = src_head[grant_idx];

    src_pop = '0;
    if (grant_vld) src_pop[grant_idx] = 1'b1;

    rr_d  = grant_vld ? src_next(grant_idx) : rr_q;
    wen_d = grant_vld && !is_null_write(gnt_entry);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      rr_q     <= SRC_ALU;
      wen_q    <= 1'b0;
      wfmode_q <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rr_q  <= rr_d;
      wen_q <= wen_d;
      // Data fields hold their last real write across idle and x0 slots.
      if (wen_d) begin
        wfmode_q <= gnt_entry.fmode;
        wreg_q   <= gnt_entry.ridx;
        wdata_q  <= gnt_entry.data;
      end
    end
  end

  assign wenable = wen_q;
  assign wfmode  = wfmode_q;
  assign wreg    = wreg_q;
  assign wdata   = wdata_q;
  assign busy    = (~&src_empty) | wen_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a queue-based reference model predicts
// each register-file write and the cycle it should appear; a monitor checks them.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int EW    = 38;
  localparam int W     = 32 + EW;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  in_valid;
  logic [2:0]  in_fmode;
  logic [4:0]  in_reg  [3];
  logic [31:0] in_data [3];

  logic        alu_ready, fpu_ready, mem_ready;
  logic        wenable, wfmode, busy;
  logic [4:0]  wreg;
  logic [31:0] wdata;

  int          total = 0;
  int          bad   = 0;
  int unsigned ecount = 0;
  int          rr = 0;
  logic [W-1:0]  exp_q [$];
  logic [EW-1:0] mq [3][$];

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .alu_valid(in_valid[0]), .alu_ready(alu_ready), .alu_fmode(in_fmode[0]),
    .alu_reg  (in_reg[0]),   .alu_data (in_data[0]),
    .fpu_valid(in_valid[1]), .fpu_ready(fpu_ready), .fpu_fmode(in_fmode[1]),
    .fpu_reg  (in_reg[1]),   .fpu_data (in_data[1]),
    .mem_valid(in_valid[2]), .mem_ready(mem_ready), .mem_fmode(in_fmode[2]),
    .mem_reg  (in_reg[2]),   .mem_data (in_data[2]),
    .wenable  (wenable),
    .wfmode   (wfmode),
    .wreg     (wreg),
    .wdata    (wdata),
    .busy     (busy)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, ecount, act, exp);
    end
  endtask

  // Reference model: per-source queues, round-robin from the source after the
  // last winner, writes visible right after the grant edge, x0 writes dropped.
  always @(posedge clk) begin
    logic [2:0]    acc;
    logic [EW-1:0] e;
    int            win;
    ecount++;
    if (rstn) begin
      for (int s = 0; s < 3; s++) mq[s].delete();
      exp_q.delete();
      rr = 0;
    end else begin
      for (int s = 0; s < 3; s++) acc[s] = in_valid[s] && (mq[s].size() < DEPTH);
      win = -1;
      for (int k = 0; k < 3; k++)
        if (win < 0 && mq[(rr + k) % 3].size() > 0) win = (rr + k) % 3;
      if (win >= 0) begin
        e  = mq[win].pop_front();
        rr = (win + 1) % 3;
        if (!(e[37] == 1'b0 && e[36:32] == 5'd0)) exp_q.push_back({ecount, e});
      end
      for (int s = 0; s < 3; s++)
        if (acc[s]) mq[s].push_back({in_fmode[s], in_reg[s], in_data[s]});
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic         exp_en;
    logic         mbusy;
    logic [W-1:0] e;
    exp_en = (exp_q.size() > 0) && (exp_q[0][W-1:EW] == ecount);
    mbusy  = exp_en || mq[0].size() > 0 || mq[1].size() > 0 || mq[2].size() > 0;
    chk("wenable",   {31'd0, wenable},   {31'd0, exp_en});
    chk("busy",      {31'd0, busy},      {31'd0, mbusy});
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, mq[0].size() < DEPTH});
    chk("fpu_ready", {31'd0, fpu_ready}, {31'd0, mq[1].size() < DEPTH});
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, mq[2].size() < DEPTH});
    if (exp_en) begin
      e = exp_q.pop_front();
      if (wenable) begin
        chk("wfmode", {31'd0, wfmode}, {31'd0, e[37]});
        chk("wreg",   {27'd0, wreg},   {27'd0, e[36:32]});
        chk("wdata",  wdata,           e[31:0]);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic f,
                         input logic [4:0] r, input logic [31:0] d);
    in_valid[s] = v;
    in_fmode[s] = f;
    in_reg[s]   = r;
    in_data[s]  = d;
  endtask

  task automatic idle(input int n);
    in_valid = '0;
    repeat (n) step();
  endtask

  initial begin
    rstn     = 1'b1;
    in_valid = '0;
    in_fmode = '0;
    for (int s = 0; s < 3; s++) begin
      in_reg[s]  = '0;
      in_data[s] = '0;
    end
    repeat (3) step();
    rstn = 1'b0;
    idle(2);

    // Single alu write, minimum latency.
    set_src(0, 1'b1, 1'b0, 5'd3, 32'h1234_5678);
    step();
    idle(4);

    // Integer x0 is suppressed; float f0 is written.
    set_src(0, 1'b1, 1'b0, 5'd0, 32'hdead_beef);
    step();
    in_valid = '0;
    set_src(1, 1'b1, 1'b1, 5'd0, 32'hcafe_f00d);
    step();
    idle(4);

    // Full three-source load: rotation, backpressure, order.
    for (int c = 0; c < 15; c++) begin
      for (int s = 0; s < 3; s++)
        set_src(s, 1'b1, 1'b1, 5'(s + 1), {8'(s), 24'(c)});
      step();
    end
    idle(8);

    // Reset with all FIFOs full: everything buffered is discarded.
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < 3; s++)
        set_src(s, 1'b1, 1'b0, 5'(8 + s), {8'hA0 + 8'(s), 24'(c)});
      step();
    end
    rstn = 1'b1;
    step();
    rstn = 1'b0;
    idle(6);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 3; s++) begin
        in_valid[s] = 1'($urandom_range(0, 1));
        in_fmode[s] = 1'($urandom_range(0, 1));
        in_reg[s]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        in_data[s]  = $urandom;
      end
      rstn = ($urandom_range(0, 99) == 0);
      step();
    end
    rstn = 1'b0;
    idle(12);

    chk("drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
